// File: rtl/nand3_bist.sv
// ---------------------------------------------------------------------------
// nand3_bist
//   Built-in self test sequencer for a single NAND3 cell. Walks all eight
//   input vectors (binary or Gray order), holds each vector for SETTLE
//   cycles, samples the cell output on one more cycle, and keeps a
//   saturating mismatch count plus the first failing vector.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; a/b/c parked at 000
//   DRIVE  | vector on a/b/c, settle counter running
//   SAMPLE | last cycle of a vector; y compared against ~(a&b&c)
//   FIN    | one-cycle wrap-up; done/pass already valid, busy drops after
//
// Ports
//   clk       : single clock, rising-edge
//   rst_n     : asynchronous active-low reset
//   start     : run request, honoured only in IDLE
//   gray      : vector order (0 binary, 1 Gray), latched when start accepted
//   abort     : terminates a run in DRIVE/SAMPLE
//   y         : output of the cell under test
//   a, b, c   : registered drives to the cell inputs
//   busy      : high while a run is in progress
//   done      : completion flag, held until next accepted start or reset
//   pass      : valid with done; 1 = no mismatches and not aborted
//   err_cnt   : mismatch count, saturating at 15
//   fail_vec  : {a,b,c} of the first mismatching vector
// ---------------------------------------------------------------------------
module nand3_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gray,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic       gray_q, gray_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fail_q, fail_d;
  logic       mismatch;

  function automatic logic [2:0] vec_of(input logic [2:0] i, input logic g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      gray_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    gray_d   = gray_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        // abort wins over a coincident start
        if (start && !abort) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          gray_d  = gray;
          vec_d   = vec_of(3'd0, gray);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_d = FIN;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          vec_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SAMPLE: begin
        // abort discards this cycle's compare
        if (abort) begin
          state_d = FIN;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          vec_d   = '0;
        end else begin
          mismatch = (y != ~(&vec_q));
          if (mismatch) begin
            if (err_q != 4'd15) err_d = err_q + 4'd1;
            if (err_q == 4'd0)  fail_d = vec_q;
          end
          if (idx_q == 3'd7) begin
            state_d = FIN;
            done_d  = 1'b1;
            // err_d so a mismatch on the final vector still clears pass
            pass_d  = (err_d == 4'd0);
            vec_d   = '0;
          end else begin
            state_d = DRIVE;
            idx_d   = idx_q + 3'd1;
            cnt_d   = '0;
            vec_d   = vec_of(idx_q + 3'd1, gray_q);
          end
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign {a, b, c} = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nand3_bist.sv
// ---------------------------------------------------------------------------
// tb_nand3_bist
//   Directed bench for nand3_bist with SETTLE=2. A behavioural cell model
//   drives y (ideal, stuck-1, stuck-0, or faulty only on vector 011).
//   Expected vector sequences are queued when a run is started and popped
//   as the DUT steps through them. Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_nand3_bist;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       gray = 1'b0;
  logic       abort = 1'b0;
  logic       y;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] fail_vec;

  int y_mode = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  localparam logic [2:0] BIN_TAB  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [2:0] GRAY_TAB [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                         3'b110, 3'b111, 3'b101, 3'b100};

  nand3_bist #(.SETTLE(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .gray     (gray),
    .abort    (abort),
    .y        (y),
    .a        (a),
    .b        (b),
    .c        (c),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  always #5 clk = ~clk;

  // cell model: 0 ideal, 1 stuck-1, 2 stuck-0, 3 wrong only on 011
  always_comb begin
    y = ~(a & b & c);
    case (y_mode)
      1:       y = 1'b1;
      2:       y = 1'b0;
      3:       if ({a, b, c} == 3'b011) y = (a & b & c);
      default: y = ~(a & b & c);
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_vectors(input logic g);
    for (int i = 0; i < 8; i++) exp_q.push_back(g ? GRAY_TAB[i] : BIN_TAB[i]);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".abc"},  8'({a, b, c}), 8'd0);
    check({tag, ".busy"}, 8'(busy), 8'd0);
    check({tag, ".done"}, 8'(done), 8'd0);
    check({tag, ".pass"}, 8'(pass), 8'd0);
    check({tag, ".err"},  8'(err_cnt), 8'd0);
    check({tag, ".fail"}, 8'(fail_vec), 8'd0);
  endtask

  // called on a falling edge; returns on a falling edge with the DUT idle
  task automatic run_full(input logic g, input int mode, input logic [3:0] e_err,
                          input logic [2:0] e_fail, input logic e_pass, input string name);
    int busy_cycles;
    logic [2:0] ev;
    busy_cycles = 0;
    y_mode = mode;
    gray   = g;
    start  = 1'b1;
    push_vectors(g);
    @(negedge clk);
    start = 1'b0;
    check({name, ".done_clr"}, 8'(done), 8'd0);
    for (int v = 0; v < 8; v++) begin
      ev = exp_q.pop_front();
      for (int k = 0; k <= S; k++) begin
        check($sformatf("%s.v%0d.abc", name, v), 8'({a, b, c}), 8'(ev));
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
    check({name, ".fin_busy"}, 8'(busy), 8'd1);
    if (busy) busy_cycles++;
    check({name, ".fin_abc"},  8'({a, b, c}), 8'd0);
    check({name, ".done"},     8'(done), 8'd1);
    check({name, ".pass"},     8'(pass), 8'(e_pass));
    check({name, ".err"},      8'(err_cnt), 8'(e_err));
    check({name, ".fail"},     8'(fail_vec), 8'(e_fail));
    @(negedge clk);
    check({name, ".busy_cycles"}, 8'(busy_cycles), 8'(8 * (S + 1) + 1));
    check({name, ".idle_busy"},   8'(busy), 8'd0);
    check({name, ".done_held"},   8'(done), 8'd1);
    check({name, ".idle_abc"},    8'({a, b, c}), 8'd0);
  endtask

  initial begin
    logic [2:0] ev;

    // reset state, sampled between edges
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort.busy", 8'(busy), 8'd0);
    check("idle_abort.abc",  8'({a, b, c}), 8'd0);
    @(negedge clk);

    run_full(1'b0, 0, 4'd0, 3'd0,     1'b1, "bin");
    run_full(1'b1, 0, 4'd0, 3'd0,     1'b1, "gray");
    run_full(1'b0, 1, 4'd1, 3'b111,   1'b0, "stuck1");
    run_full(1'b0, 2, 4'd7, 3'b000,   1'b0, "stuck0");

    // abort on vector 3 SAMPLE with a mismatching y; start mid-run ignored
    y_mode = 3;
    gray   = 1'b0;
    start  = 1'b1;
    push_vectors(1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 4 * (S + 1); t++) begin
      ev = exp_q[0];
      check($sformatf("abort.t%0d.abc", t), 8'({a, b, c}), 8'(ev));
      if (t % (S + 1) == S) void'(exp_q.pop_front());
      if (t == 5) begin
        start = 1'b1;
        gray  = 1'b1;
      end
      if (t == 6) begin
        start = 1'b0;
        gray  = 1'b0;
      end
      if (t == 4 * (S + 1) - 1) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    exp_q.delete();
    check("abort.fin_busy", 8'(busy), 8'd1);
    check("abort.done",     8'(done), 8'd1);
    check("abort.pass",     8'(pass), 8'd0);
    check("abort.err",      8'(err_cnt), 8'd0);
    check("abort.abc",      8'({a, b, c}), 8'd0);
    @(negedge clk);
    check("abort.idle_busy", 8'(busy), 8'd0);
    check("abort.done_held", 8'(done), 8'd1);

    // reset mid-run at vector 5 with errors accumulated
    y_mode = 2;
    gray   = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 5 * (S + 1) + 1; t++) @(negedge clk);
    check("prerst.abc", 8'({a, b, c}), 8'd5);
    check("prerst.err", 8'(err_cnt), 8'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    check_idle_zero("midrst_hold");
    // start already high when reset releases
    rst_n = 1'b1;
    run_full(1'b0, 0, 4'd0, 3'd0, 1'b1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nand3_bist.md
NAND3_BIST -- requirements
Module: nand3_bist

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving the number of cycles to hold a vector before sampling Y; legal range 1..15.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port START, input, 1, a test request, honoured only in IDLE.
REQ-005 SHALL have port GRAY, input, 1, selecting vector order (0 = binary, 1 = Gray), sampled on the START-accept edge.
REQ-006 SHALL have port ABORT, input, 1, which terminates a run in progress.
REQ-007 SHALL have port Y, input, 1, the output of the NAND3 cell under test.
REQ-008 SHALL have ports A, B, C, output, 1 each, registered drives to the cell inputs.
REQ-009 SHALL have port BUSY, output, 1, high while a run is in progress.
REQ-010 SHALL have port DONE, output, 1, a completion flag held until the next accepted START or reset.
REQ-011 SHALL have port PASS, output, 1, valid while DONE=1: 1 = no mismatches and not aborted.
REQ-012 SHALL have port ERR_CNT, output, 4, the mismatch count, saturating.
REQ-013 SHALL have port FAIL_VEC, output, 3, holding {A,B,C} of the first mismatching vector.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and FIN.
- IDLE -> DRIVE on START=1 and ABORT=0.
- DRIVE -> SAMPLE when the settle counter reaches SETTLE-1.
- SAMPLE -> DRIVE if the vector index is below 7; SAMPLE -> FIN if the index is 7.
- FIN -> IDLE unconditionally, after one cycle.
REQ-015 SHALL, on the START-accept edge, do all of the following: clear ERR_CNT, FAIL_VEC, DONE and PASS; set the vector index to 0; latch GRAY; load the first vector onto A/B/C; set BUSY.
REQ-016 SHALL hold A/B/C constant for SETTLE DRIVE cycles plus the one SAMPLE cycle, so each vector lasts exactly SETTLE+1 cycles.
REQ-017 SHALL compare Y against ~(A&B&C) only in SAMPLE; Y is ignored in every other state.
REQ-018 SHALL handle a SAMPLE mismatch as follows:
- ERR_CNT increments, saturating at 15.
- If ERR_CNT was 0 before the mismatch, FAIL_VEC captures {A,B,C}.
REQ-019 SHALL apply vectors in order by index i:
- binary order: {A,B,C} = i;
- Gray order: {A,B,C} = i ^ (i>>1), i.e. 000,001,011,010,110,111,101,100.
REQ-020 SHALL load the next vector onto A/B/C on the SAMPLE -> DRIVE edge.
REQ-021 SHALL, on entry to FIN:
- set DONE=1;
- set PASS=1 only if ERR_CNT==0, including a mismatch on the final SAMPLE cycle;
- drive A/B/C to 000.
REQ-022 SHALL clear BUSY on the FIN -> IDLE edge, so BUSY spans exactly 8*(SETTLE+1)+1 cycles.
REQ-023 SHALL ignore START while BUSY=1, with no effect on state, counters or outputs.
REQ-024 SHALL handle ABORT=1 in DRIVE or SAMPLE as follows:
- next state is FIN, with DONE=1 and PASS=0;
- ERR_CNT and FAIL_VEC keep their values;
- ABORT takes priority over a coincident SAMPLE compare, so that cycle's compare is discarded.
REQ-025 SHALL give ABORT priority over START when both are high in IDLE; the block stays in IDLE.
REQ-026 SHALL treat ABORT in IDLE or FIN as having no effect.
REQ-027 SHALL keep A/B/C at 000 whenever BUSY=0.

Reset
REQ-028 SHALL, while RST_N=0 and independent of CLK, force the following:
- state to IDLE;
- A=B=C=0;
- BUSY=0, DONE=0, PASS=0;
- ERR_CNT=0, FAIL_VEC=0;
- vector index and settle counter to 0.
REQ-029 SHALL abandon a run when reset is asserted mid-run, without setting DONE.
REQ-030 SHALL require a fresh START after reset deassertion; START held high across the deassertion edge is accepted on the first rising CLK edge with RST_N=1.

Verification
REQ-031 SHALL pass this case: SETTLE=2, GRAY=0, ideal NAND model on Y, START pulse -> A/B/C step 000..111, each held 3 cycles; BUSY high 25 cycles; DONE=1, PASS=1, ERR_CNT=0.
REQ-032 SHALL pass this case: GRAY=1 -> A/B/C sequence 000,001,011,010,110,111,101,100; completion identical to REQ-031.
REQ-033 SHALL pass this case: Y stuck at 1 -> only vector 111 mismatches; ERR_CNT=1, FAIL_VEC=111, PASS=0.
REQ-034 SHALL pass this case: Y stuck at 0, GRAY=0 -> ERR_CNT=7, FAIL_VEC=000, PASS=0.
REQ-035 SHALL pass this case: ABORT during the vector-3 SAMPLE cycle with a mismatch on Y -> compare discarded, next cycle in FIN with DONE=1 and PASS=0, ERR_CNT unchanged; START asserted while BUSY=1 is ignored.
REQ-036 SHALL pass this case: RST_N low at vector 5, between clock edges -> all outputs 0 immediately; after release, a START runs a complete sequence from vector 0.
